// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core.
// Produces PC/IF/ID stall, IF/ID flush, ID/EX bubble and memory-wait freeze controls,
// plus registered EX forwarding selects.
// Optional performance counters are enabled by defining HAZARD_PERF_EN.
module hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       ex_valid,
  input  logic [4:0] ex_rd,
  input  logic       ex_regwrite,
  input  logic       ex_memread,
  input  logic       mem_valid,
  input  logic [4:0] mem_rd,
  input  logic       mem_regwrite,
  input  logic       branch_taken,
  input  logic       dmem_req,
  input  logic       dmem_ready,
  output logic       pc_stall,
  output logic       ifid_stall,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic       pipe_freeze,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic [1:0] state
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StMemWait = 2'b01,
    StFlush   = 2'b10
  } state_e;

  localparam logic [2:0] FlushInit = 3'(FLUSH_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] fwd_a_q, fwd_a_d;
  logic [1:0] fwd_b_q, fwd_b_d;

  logic mem_stall;
  logic load_use;

  assign mem_stall = dmem_req & ~dmem_ready;
  assign load_use  = id_valid & ex_valid & ex_memread & (ex_rd != 5'd0) &
                     ((id_use_rs1 & (ex_rd == id_rs1)) | (id_use_rs2 & (ex_rd == id_rs2)));

  // Select the producer that will sit in EX/MEM (01) or MEM/WB (10) next cycle; x0 never matches.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (ex_valid && ex_regwrite && ex_rd != 5'd0 && ex_rd == rs) begin
      return 2'b01;
    end else if (mem_valid && mem_regwrite && mem_rd != 5'd0 && mem_rd == rs) begin
      return 2'b10;
    end else begin
      return 2'b00;
    end
  endfunction

  // State, flush counter and forwarding-select registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      cnt_q   <= 3'd0;
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  // Next-state and flush-counter logic; memory stall always wins over branch and load-use.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StRun: begin
        if (mem_stall) begin
          state_d = StMemWait;
        end else if (branch_taken && FLUSH_CYCLES > 1) begin
          state_d = StFlush;
          cnt_d   = FlushInit;
        end
      end
      StMemWait: begin
        // A branch in EX is frozen here and re-presents once back in RUN.
        if (dmem_ready) state_d = StRun;
      end
      StFlush: begin
        if (!mem_stall) begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Stall/flush/bubble/freeze outputs decoded from state and this cycle's inputs.
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    unique case (state_q)
      StRun: begin
        if (mem_stall) begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          pipe_freeze = 1'b1;
        end else if (branch_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (load_use) begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_bubble = 1'b1;
        end
      end
      StMemWait: begin
        if (!dmem_ready) begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          pipe_freeze = 1'b1;
        end
      end
      StFlush: begin
        if (mem_stall) begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          pipe_freeze = 1'b1;
        end else begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Forwarding selects follow ID/EX: hold on freeze, clear on bubble, else load the new match.
  always_comb begin
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    if (pipe_freeze) begin
      fwd_a_d = fwd_a_q;
      fwd_b_d = fwd_b_q;
    end else if (idex_bubble || ifid_flush) begin
      fwd_a_d = 2'b00;
      fwd_b_d = 2'b00;
    end else begin
      fwd_a_d = fwd_sel(id_rs1);
      fwd_b_d = fwd_sel(id_rs2);
    end
  end

  assign fwd_a = fwd_a_q;
  assign fwd_b = fwd_b_q;
  assign state = state_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             flush_accept;

  assign flush_accept = (state_q == StRun) & ~mem_stall & branch_taken;

  // Saturating counters for stall cycles and accepted taken branches.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_accept && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: two instances (FLUSH_CYCLES=3 and 1), a vector table,
// hand-written multi-cycle sequences and randomized stimulus against a behavioural model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_use_rs1, id_use_rs2;
  logic [4:0] id_rs1, id_rs2;
  logic       ex_valid, ex_regwrite, ex_memread;
  logic [4:0] ex_rd;
  logic       mem_valid, mem_regwrite;
  logic [4:0] mem_rd;
  logic       branch_taken, dmem_req, dmem_ready;

  logic [1:0] pc_stall_w, ifid_stall_w, ifid_flush_w, idex_bubble_w, pipe_freeze_w;
  logic [1:0] fwd_a_w [2];
  logic [1:0] fwd_b_w [2];
  logic [1:0] state_w [2];
  logic [4:0] ctl_w   [2];
`ifdef HAZARD_PERF_EN
  logic [31:0] pstall_w [2];
  logic [31:0] pflush_w [2];
`endif

  always #5 clk = ~clk;

  // Instance 0 uses a 3-cycle flush, instance 1 the single-cycle default.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    hazard_ctrl #(
      .FLUSH_CYCLES((g == 0) ? 3 : 1),
      .CNT_W       (32)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .id_valid    (id_valid),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_use_rs1  (id_use_rs1),
      .id_use_rs2  (id_use_rs2),
      .ex_valid    (ex_valid),
      .ex_rd       (ex_rd),
      .ex_regwrite (ex_regwrite),
      .ex_memread  (ex_memread),
      .mem_valid   (mem_valid),
      .mem_rd      (mem_rd),
      .mem_regwrite(mem_regwrite),
      .branch_taken(branch_taken),
      .dmem_req    (dmem_req),
      .dmem_ready  (dmem_ready),
      .pc_stall    (pc_stall_w[g]),
      .ifid_stall  (ifid_stall_w[g]),
      .ifid_flush  (ifid_flush_w[g]),
      .idex_bubble (idex_bubble_w[g]),
      .pipe_freeze (pipe_freeze_w[g]),
      .fwd_a       (fwd_a_w[g]),
      .fwd_b       (fwd_b_w[g]),
      .state       (state_w[g])
`ifdef HAZARD_PERF_EN
      ,
      .perf_stall_cnt(pstall_w[g]),
      .perf_flush_cnt(pflush_w[g])
`endif
    );
    // {pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze}
    assign ctl_w[g] = {pc_stall_w[g], ifid_stall_w[g], ifid_flush_w[g], idex_bubble_w[g],
                       pipe_freeze_w[g]};
  end

  localparam logic [4:0] CtlFreeze = 5'b11001;
  localparam logic [4:0] CtlFlush  = 5'b00110;
  localparam logic [4:0] CtlLoadU  = 5'b11010;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_valid = 0; ex_rd = 0; ex_regwrite = 0; ex_memread = 0;
    mem_valid = 0; mem_rd = 0; mem_regwrite = 0;
    branch_taken = 0; dmem_req = 0; dmem_ready = 0;
  endtask

  // ---------------- behavioural reference model ----------------
  bit          m_wait [2];   // waiting on data memory
  int          m_left [2];   // flush cycles still owed after the branch cycle
  logic [1:0]  m_fa   [2];
  logic [1:0]  m_fb   [2];
  int unsigned m_pst  [2];
  int unsigned m_pfl  [2];

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (rs == 0) return 2'd0;
    if (ex_valid && ex_regwrite && ex_rd == rs) return 2'd1;
    if (mem_valid && mem_regwrite && mem_rd == rs) return 2'd2;
    return 2'd0;
  endfunction

  function automatic bit ref_load_use();
    bit hit1 = id_use_rs1 && id_rs1 == ex_rd;
    bit hit2 = id_use_rs2 && id_rs2 == ex_rd;
    return id_valid && ex_valid && ex_memread && ex_rd != 0 && (hit1 || hit2);
  endfunction

  function automatic logic [4:0] ref_ctl(input int i);
    bit ms = dmem_req && !dmem_ready;
    if (m_wait[i]) return dmem_ready ? 5'b0 : CtlFreeze;
    if (m_left[i] > 0) return ms ? CtlFreeze : CtlFlush;
    if (ms) return CtlFreeze;
    if (branch_taken) return CtlFlush;
    if (ref_load_use()) return CtlLoadU;
    return 5'b0;
  endfunction

  function automatic logic [1:0] ref_state(input int i);
    if (m_wait[i]) return 2'b01;
    if (m_left[i] > 0) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_wait[i] = 0; m_left[i] = 0; m_fa[i] = 0; m_fb[i] = 0; m_pst[i] = 0; m_pfl[i] = 0;
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_adv(input int i, input int fc);
    logic [4:0] c;
    bit ms;
    if (rst) begin
      m_wait[i] = 0; m_left[i] = 0; m_fa[i] = 0; m_fb[i] = 0; m_pst[i] = 0; m_pfl[i] = 0;
      return;
    end
    c  = ref_ctl(i);
    ms = dmem_req && !dmem_ready;
    if (c[4]) m_pst[i]++;
    if (!m_wait[i] && m_left[i] == 0 && !ms && branch_taken) m_pfl[i]++;
    if (c[0]) begin
      // freeze: hold
    end else if (c[1]) begin
      m_fa[i] = 0; m_fb[i] = 0;
    end else begin
      m_fa[i] = ref_fwd(id_rs1); m_fb[i] = ref_fwd(id_rs2);
    end
    if (m_wait[i]) m_wait[i] = !dmem_ready;
    else if (m_left[i] > 0) begin
      if (!ms) m_left[i]--;
    end else if (ms) m_wait[i] = 1;
    else if (branch_taken) m_left[i] = fc - 1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       idv;
    logic [4:0] rs1, rs2;
    logic       u1, u2, exv;
    logic [4:0] exrd;
    logic       exrw, exmr, memv;
    logic [4:0] memrd;
    logic       memrw, br, req, rdy;
    logic [4:0] ctl;
    logic [1:0] fa, fb;
  } vec_t;

  vec_t vecs [13];

  initial begin
    vecs[0]  = '{1, 5, 2, 1, 1, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0, 5'b11010, 0, 0}; // load-use rs1
    vecs[1]  = '{1, 0, 0, 1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0}; // x0 load
    vecs[2]  = '{1, 3, 7, 1, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 1}; // ALU -> fwd_b 01
    vecs[3]  = '{1, 4, 1, 1, 1, 0, 0, 0, 0, 1, 4, 1, 0, 0, 0, 5'b00000, 2, 0}; // MEM match
    vecs[4]  = '{1, 6, 1, 1, 1, 1, 6, 1, 0, 1, 6, 1, 0, 0, 0, 5'b00000, 1, 0}; // EX over MEM
    vecs[5]  = '{1, 5, 0, 1, 0, 1, 5, 1, 1, 0, 0, 0, 1, 0, 0, 5'b00110, 0, 0}; // br + load-use
    vecs[6]  = '{1, 5, 0, 1, 0, 1, 5, 1, 0, 0, 0, 0, 1, 1, 0, 5'b11001, 0, 0}; // mem_stall + br
    vecs[7]  = '{1, 9, 5, 1, 1, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0, 5'b11010, 0, 0}; // load-use rs2
    vecs[8]  = '{1, 5, 2, 0, 1, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0, 5'b00000, 1, 0}; // rs1 unused
    vecs[9]  = '{0, 5, 2, 1, 1, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0, 5'b00000, 1, 0}; // ID invalid
    vecs[10] = '{1, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 5'b00000, 0, 0}; // mem_rd x0
    vecs[11] = '{1, 1, 2, 1, 1, 0, 0, 0, 0, 1, 2, 1, 0, 1, 1, 5'b00000, 0, 2}; // req & ready
    vecs[12] = '{1, 3, 0, 1, 0, 1, 3, 0, 0, 1, 3, 1, 0, 0, 0, 5'b00000, 2, 0}; // EX no regwrite
  end

  initial begin
    rst = 1;
    idle();
    repeat (2) tick();
    rst = 0;
    model_reset();

    // Reset state
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_state%0d", i), 32'(state_w[i]), 32'd0);
      chk($sformatf("reset_ctl%0d", i), 32'(ctl_w[i]), 32'd0);
      chk($sformatf("reset_fwd%0d", i), 32'({fwd_a_w[i], fwd_b_w[i]}), 32'd0);
`ifdef HAZARD_PERF_EN
      chk($sformatf("reset_perf%0d", i), pstall_w[i] | pflush_w[i], 32'd0);
`endif
    end

    // Table: single cycle from RUN, then forwarding after the edge
    for (int v = 0; v < 13; v++) begin
      do_reset();
      id_valid = vecs[v].idv; id_rs1 = vecs[v].rs1; id_rs2 = vecs[v].rs2;
      id_use_rs1 = vecs[v].u1; id_use_rs2 = vecs[v].u2;
      ex_valid = vecs[v].exv; ex_rd = vecs[v].exrd;
      ex_regwrite = vecs[v].exrw; ex_memread = vecs[v].exmr;
      mem_valid = vecs[v].memv; mem_rd = vecs[v].memrd; mem_regwrite = vecs[v].memrw;
      branch_taken = vecs[v].br; dmem_req = vecs[v].req; dmem_ready = vecs[v].rdy;
      #1;
      for (int i = 0; i < 2; i++) chk($sformatf("vec%0d_ctl%0d", v, i), 32'(ctl_w[i]),
                                      32'(vecs[v].ctl));
      tick();
      #1;
      chk($sformatf("vec%0d_fwd_a", v), 32'(fwd_a_w[0]), 32'(vecs[v].fa));
      chk($sformatf("vec%0d_fwd_b", v), 32'(fwd_b_w[0]), 32'(vecs[v].fb));
    end

    // Load-use then advance with the load in MEM
    do_reset();
    id_valid = 1; id_rs1 = 5; id_use_rs1 = 1;
    ex_valid = 1; ex_rd = 5; ex_regwrite = 1; ex_memread = 1;
    #1 chk("lu_stall", 32'(ctl_w[0]), 32'(CtlLoadU));
    tick();
    ex_valid = 0; ex_memread = 0; ex_regwrite = 0; mem_valid = 1; mem_rd = 5; mem_regwrite = 1;
    #1 chk("lu_bubble_fwd", 32'(fwd_a_w[0]), 32'd0);
    chk("lu_clear", 32'(ctl_w[0]), 32'd0);
    tick();
    #1 chk("lu_fwd_mem", 32'(fwd_a_w[0]), 32'd2);

    // Memory wait: ready low for three cycles, then high
    do_reset();
    dmem_req = 1;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("mw_ctl%0d", k), 32'(ctl_w[0]), 32'(CtlFreeze));
      chk($sformatf("mw_state%0d", k), 32'(state_w[0]), (k == 0) ? 32'd0 : 32'd1);
      tick();
    end
    dmem_ready = 1;
    #1 chk("mw_ready_ctl", 32'(ctl_w[0]), 32'd0);
    chk("mw_ready_state", 32'(state_w[0]), 32'd1);
    tick();
    idle();
    #1 chk("mw_back_run", 32'(state_w[0]), 32'd0);

    // Three-cycle flush extended by a one-cycle memory stall
    do_reset();
    branch_taken = 1;
    #1 chk("fl0_ctl", 32'(ctl_w[0]), 32'(CtlFlush));
    tick();
    branch_taken = 0; dmem_req = 1;
    #1 chk("fl1_ctl", 32'(ctl_w[0]), 32'(CtlFreeze));
    chk("fl1_state", 32'(state_w[0]), 32'd2);
    chk("fl1_state_fc1", 32'(state_w[1]), 32'd0);
    tick();
    dmem_ready = 1;
    #1 chk("fl2_ctl", 32'(ctl_w[0]), 32'(CtlFlush));
    chk("fl2_fc1_ctl", 32'(ctl_w[1]), 32'd0);
    tick();
    dmem_req = 0; dmem_ready = 0;
    #1 chk("fl3_ctl", 32'(ctl_w[0]), 32'(CtlFlush));
    chk("fl3_state", 32'(state_w[0]), 32'd2);
    tick();
    #1 chk("fl4_ctl", 32'(ctl_w[0]), 32'd0);
    chk("fl4_state", 32'(state_w[0]), 32'd0);

    // Memory stall and branch together: freeze first, flush after ready
    do_reset();
    dmem_req = 1; branch_taken = 1;
    #1 chk("msbr_ctl", 32'(ctl_w[0]), 32'(CtlFreeze));
    tick();
    dmem_ready = 1;
    #1 chk("msbr_ready", 32'(ctl_w[0]), 32'd0);
    tick();
    dmem_req = 0; dmem_ready = 0;
    #1 chk("msbr_flush", 32'(ctl_w[0]), 32'(CtlFlush));

    // Reset mid-MEM_WAIT with a nonzero forwarding select held
    do_reset();
    ex_valid = 1; ex_rd = 3; ex_regwrite = 1; id_rs1 = 3;
    tick();
    dmem_req = 1;
    tick();
    #1 chk("rw_state", 32'(state_w[0]), 32'd1);
    chk("rw_fwd_held", 32'(fwd_a_w[0]), 32'd1);
    rst = 1;
    tick();
    rst = 0; idle();
    #1 chk("rw_state_after", 32'(state_w[0]), 32'd0);
    chk("rw_ctl_after", 32'(ctl_w[0]), 32'd0);
    chk("rw_fwd_after", 32'(fwd_a_w[0]), 32'd0);

    // Reset mid-FLUSH
    do_reset();
    branch_taken = 1;
    tick();
    branch_taken = 0;
    #1 chk("rf_state", 32'(state_w[0]), 32'd2);
    rst = 1;
    tick();
    rst = 0;
    #1 chk("rf_state_after", 32'(state_w[0]), 32'd0);
    chk("rf_ctl_after", 32'(ctl_w[0]), 32'd0);
`ifdef HAZARD_PERF_EN
    chk("rf_perf_after", pstall_w[0] | pflush_w[0], 32'd0);
`endif

    // Randomized run against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(0, 99) == 0);
      id_valid     = ($urandom_range(0, 3) != 0);
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      id_use_rs1   = 1'($urandom);
      id_use_rs2   = 1'($urandom);
      ex_valid     = ($urandom_range(0, 3) != 0);
      ex_rd        = 5'($urandom_range(0, 3));
      ex_regwrite  = 1'($urandom);
      ex_memread   = 1'($urandom);
      mem_valid    = 1'($urandom);
      mem_rd       = 5'($urandom_range(0, 3));
      mem_regwrite = 1'($urandom);
      branch_taken = ($urandom_range(0, 7) == 0);
      dmem_req     = ($urandom_range(0, 3) == 0);
      dmem_ready   = 1'($urandom);
      #1;
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("rnd_state%0d", i), 32'(state_w[i]), 32'(ref_state(i)));
        chk($sformatf("rnd_fwd%0d", i), 32'({fwd_a_w[i], fwd_b_w[i]}),
            32'({m_fa[i], m_fb[i]}));
        if (!rst) chk($sformatf("rnd_ctl%0d", i), 32'(ctl_w[i]), 32'(ref_ctl(i)));
`ifdef HAZARD_PERF_EN
        chk($sformatf("rnd_pstall%0d", i), pstall_w[i], m_pst[i]);
        chk($sformatf("rnd_pflush%0d", i), pflush_w[i], m_pfl[i]);
`endif
      end
      model_adv(0, 3);
      model_adv(1, 1);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
